// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the 32-bit MIPS core: registers the adder result, derives
// ALU flags, detects alignment/overflow faults and raises precise exceptions plus MEM->EX forwarding.
module ex_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_sum,
    input  logic [31:0] ex_cout,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_pc,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_ovf_trap,
    input  logic        stall,
    input  logic        flush,
    input  logic        exc_ack,
    output logic        mem_valid,
    output logic [31:0] mem_result,
    output logic [31:0] mem_store_data,
    output logic [31:0] mem_pc,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic        mem_zero,
    output logic        mem_carry,
    output logic        mem_ovf,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        exc_pending,
    output logic [1:0]  exc_cause,
    output logic [31:0] epc,
    output logic        exc_flush
);
    logic        valid_q, reg_write_q, mem_read_q, mem_write_q;
    logic        zero_q, carry_q, ovf_q;
    logic [31:0] result_q, store_data_q, pc_q, epc_q;
    logic [4:0]  rd_q;
    logic        pending_q, exc_flush_q;
    logic [1:0]  cause_q;

    logic        zero_d, carry_d, ovf_d, addr_err_d, fault_d;
    logic [1:0]  cause_d;

    always_comb begin
        zero_d     = (ex_sum == 32'd0);
        carry_d    = ex_cout[31];
        ovf_d      = ex_cout[31] ^ ex_cout[30];
        addr_err_d = (ex_mem_read | ex_mem_write) & (ex_sum[1:0] != 2'b00);
        fault_d    = ex_valid & ((ex_ovf_trap & ovf_d) | addr_err_d);
        // Overflow outranks the alignment check; a load outranks a store.
        if (ex_ovf_trap && ovf_d)
            cause_d = 2'b01;
        else if (ex_mem_read)
            cause_d = 2'b10;
        else
            cause_d = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            zero_q       <= 1'b0;
            carry_q      <= 1'b0;
            ovf_q        <= 1'b0;
            result_q     <= 32'd0;
            store_data_q <= 32'd0;
            pc_q         <= 32'd0;
            rd_q         <= 5'd0;
            epc_q        <= 32'd0;
            cause_q      <= 2'b00;
            pending_q    <= 1'b0;
            exc_flush_q  <= 1'b0;
        end else begin
            exc_flush_q <= 1'b0;
            if (exc_ack)
                pending_q <= 1'b0;
            if (flush) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                zero_q      <= 1'b0;
                carry_q     <= 1'b0;
                ovf_q       <= 1'b0;
            end else if (!stall) begin
                valid_q      <= ex_valid;
                reg_write_q  <= ex_reg_write & ~fault_d;
                mem_read_q   <= ex_mem_read & ~fault_d;
                mem_write_q  <= ex_mem_write & ~fault_d;
                zero_q       <= zero_d;
                carry_q      <= carry_d;
                ovf_q        <= ovf_d;
                result_q     <= ex_sum;
                store_data_q <= ex_store_data;
                pc_q         <= ex_pc;
                rd_q         <= ex_rd;
                // An ack on the same edge frees the slot, so the new fault is recorded.
                if (fault_d && (!pending_q || exc_ack)) begin
                    pending_q   <= 1'b1;
                    cause_q     <= cause_d;
                    epc_q       <= ex_pc;
                    exc_flush_q <= 1'b1;
                end
            end
        end
    end

    assign mem_valid      = valid_q;
    assign mem_result     = result_q;
    assign mem_store_data = store_data_q;
    assign mem_pc         = pc_q;
    assign mem_rd         = rd_q;
    assign mem_reg_write  = reg_write_q;
    assign mem_mem_read   = mem_read_q;
    assign mem_mem_write  = mem_write_q;
    assign mem_zero       = zero_q;
    assign mem_carry      = carry_q;
    assign mem_ovf        = ovf_q;
    assign fwd_valid      = valid_q & reg_write_q & (rd_q != 5'd0);
    assign fwd_rd         = rd_q;
    assign fwd_data       = result_q;
    assign exc_pending    = pending_q;
    assign exc_cause      = cause_q;
    assign epc            = epc_q;
    assign exc_flush      = exc_flush_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios then randomized traffic, all checked
// every cycle against a behavioural model of the stage's architectural state.
module tb_ex_mem_stage;
    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_ovf_trap;
    logic        stall, flush, exc_ack;
    logic [31:0] ex_sum, ex_cout, ex_store_data, ex_pc;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic        mem_zero, mem_carry, mem_ovf, fwd_valid, exc_pending, exc_flush;
    logic [31:0] mem_result, mem_store_data, mem_pc, fwd_data, epc;
    logic [4:0]  mem_rd, fwd_rd;
    logic [1:0]  exc_cause;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model state
    logic        m_valid, m_rw, m_mr, m_mw, m_zero, m_carry, m_ovf, m_pend, m_eflush;
    logic [31:0] m_result, m_store, m_pc, m_epc;
    logic [4:0]  m_rd;
    logic [1:0]  m_cause;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_sum(ex_sum), .ex_cout(ex_cout),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_ovf_trap(ex_ovf_trap), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_pc(mem_pc), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_zero(mem_zero),
        .mem_carry(mem_carry), .mem_ovf(mem_ovf), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .exc_pending(exc_pending), .exc_cause(exc_cause), .epc(epc),
        .exc_flush(exc_flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Carry-out of every bit position of a ripple add a+b.
    function automatic logic [31:0] ripple_cout(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] v = '0;
        int unsigned c = 0;
        for (int i = 0; i < 32; i++) begin
            c = (int'(a[i]) + int'(b[i]) + c) / 2;
            v[i] = (c != 0);
        end
        return v;
    endfunction

    task automatic model_step();
        bit ovf, misaligned, fault, was_pending;
        if (reset) begin
            {m_valid, m_rw, m_mr, m_mw, m_zero, m_carry, m_ovf, m_pend, m_eflush} = '0;
            m_result = 0; m_store = 0; m_pc = 0; m_epc = 0; m_rd = 0; m_cause = 0;
            return;
        end
        was_pending = m_pend;
        m_eflush = 0;
        if (exc_ack) m_pend = 0;
        if (flush) begin
            {m_valid, m_rw, m_mr, m_mw, m_zero, m_carry, m_ovf} = '0;
        end else if (!stall) begin
            ovf        = (((ex_cout >> 31) ^ (ex_cout >> 30)) & 32'd1) != 0;
            misaligned = (ex_mem_read || ex_mem_write) && (ex_sum % 4 != 0);
            fault      = ex_valid && ((ex_ovf_trap && ovf) || misaligned);
            m_valid  = ex_valid;
            m_rw     = ex_reg_write && !fault;
            m_mr     = ex_mem_read && !fault;
            m_mw     = ex_mem_write && !fault;
            m_zero   = (ex_sum == 0);
            m_carry  = (ex_cout >> 31) != 0;
            m_ovf    = ovf;
            m_result = ex_sum; m_store = ex_store_data; m_pc = ex_pc; m_rd = ex_rd;
            if (fault && (!was_pending || exc_ack)) begin
                m_pend = 1; m_epc = ex_pc; m_eflush = 1;
                m_cause = (ex_ovf_trap && ovf) ? 2'd1 : (ex_mem_read ? 2'd2 : 2'd3);
            end
        end
    endtask

    task automatic check_outputs();
        chk("valid", 32'(mem_valid), 32'(m_valid));
        chk("reg_write", 32'(mem_reg_write), 32'(m_rw));
        chk("mem_read", 32'(mem_mem_read), 32'(m_mr));
        chk("mem_write", 32'(mem_mem_write), 32'(m_mw));
        chk("zero", 32'(mem_zero), 32'(m_zero));
        chk("carry", 32'(mem_carry), 32'(m_carry));
        chk("ovf", 32'(mem_ovf), 32'(m_ovf));
        chk("pending", 32'(exc_pending), 32'(m_pend));
        chk("cause", 32'(exc_cause), 32'(m_cause));
        chk("epc", epc, m_epc);
        chk("exc_flush", 32'(exc_flush), 32'(m_eflush));
        chk("fwd_valid", 32'(fwd_valid), 32'(m_valid && m_rw && m_rd != 0));
        // Data fields are undefined after a flush until the next real capture.
        if (m_valid) begin
            chk("result", mem_result, m_result);
            chk("store_data", mem_store_data, m_store);
            chk("pc", mem_pc, m_pc);
            chk("rd", 32'(mem_rd), 32'(m_rd));
            chk("fwd_rd", 32'(fwd_rd), 32'(m_rd));
            chk("fwd_data", fwd_data, m_result);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        $display("cyc %0d rst=%0b stl=%0b fl=%0b ack=%0b v=%0b sum=%h pc=%h -> v=%0b res=%h pend=%0b cause=%0d epc=%h xf=%0b",
                 cyc, reset, stall, flush, exc_ack, ex_valid, ex_sum, ex_pc,
                 mem_valid, mem_result, exc_pending, exc_cause, epc, exc_flush);
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0; exc_ack = 0;
        ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_ovf_trap = 0;
        ex_sum = 0; ex_cout = 0; ex_store_data = 0; ex_pc = 0; ex_rd = 0;
    endtask

    task automatic instr(input logic [31:0] sum, input logic [31:0] cout, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic trap);
        idle();
        ex_valid = 1; ex_sum = sum; ex_cout = cout; ex_pc = pc; ex_rd = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_ovf_trap = trap;
        ex_store_data = 32'hA5A5_0000 ^ pc;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        chk("rst_result", mem_result, 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_pc", mem_pc, 32'd0);

        // Plain add forwarded back to EX
        instr(32'h10, 32'h0, 32'h100, 5'd5, 1, 0, 0, 0); step();
        chk("add_result", mem_result, 32'h10);
        chk("add_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("add_fwd_rd", 32'(fwd_rd), 32'd5);

        // Trapping overflow, then the pulse drops, then acknowledge
        instr(32'h8000_0000, 32'h4000_0000, 32'h400, 5'd3, 1, 0, 0, 1); step();
        chk("ovf_flag", 32'(mem_ovf), 32'd1);
        chk("ovf_rw_supp", 32'(mem_reg_write), 32'd0);
        chk("ovf_cause", 32'(exc_cause), 32'd1);
        chk("ovf_epc", epc, 32'h400);
        chk("ovf_xflush", 32'(exc_flush), 32'd1);
        idle(); step();
        chk("ovf_xflush_drop", 32'(exc_flush), 32'd0);
        chk("ovf_still_pend", 32'(exc_pending), 32'd1);
        idle(); exc_ack = 1; step();
        chk("ack_clear", 32'(exc_pending), 32'd0);

        // addu: same overflow, no trap
        instr(32'h8000_0000, 32'h4000_0000, 32'h404, 5'd3, 1, 0, 0, 0); step();
        chk("addu_rw", 32'(mem_reg_write), 32'd1);
        chk("addu_nopend", 32'(exc_pending), 32'd0);

        // Misaligned store, then a second fault while pending
        instr(32'h1002, 32'h0, 32'h500, 5'd0, 0, 0, 1, 0); step();
        chk("st_mw_supp", 32'(mem_mem_write), 32'd0);
        chk("st_cause", 32'(exc_cause), 32'd3);
        instr(32'h8000_0000, 32'h4000_0000, 32'h600, 5'd4, 1, 0, 0, 1); step();
        chk("second_epc", epc, 32'h500);
        chk("second_cause", 32'(exc_cause), 32'd3);
        chk("second_noflush", 32'(exc_flush), 32'd0);
        idle(); exc_ack = 1; step();

        // Zero/carry flags with rd=0
        instr(32'h0, 32'hC000_0000, 32'h700, 5'd0, 1, 0, 0, 0); step();
        chk("zc_zero", 32'(mem_zero), 32'd1);
        chk("zc_carry", 32'(mem_carry), 32'd1);
        chk("zc_ovf", 32'(mem_ovf), 32'd0);
        chk("zc_fwd_r0", 32'(fwd_valid), 32'd0);

        // Stall holds, stall+flush inserts bubble without recording a fault
        instr(32'h1234, 32'h0, 32'h800, 5'd7, 1, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            instr($urandom, $urandom, $urandom, 5'($urandom), 1, 0, 0, 1);
            stall = 1; step();
            chk("stall_hold", mem_result, 32'h1234);
        end
        instr(32'h8000_0000, 32'h4000_0000, 32'h900, 5'd7, 1, 0, 0, 1);
        stall = 1; flush = 1; step();
        chk("sf_bubble", 32'(mem_valid), 32'd0);
        chk("sf_noexc", 32'(exc_pending), 32'd0);

        // Reset while pending and stalled
        instr(32'h3, 32'h0, 32'hA00, 5'd2, 1, 1, 0, 0); step();
        idle(); reset = 1; stall = 1; step();
        chk("rst_pend", 32'(exc_pending), 32'd0);
        chk("rst_epc2", epc, 32'd0);

        // Ack coincident with a new overflow
        instr(32'h8000_0000, 32'h4000_0000, 32'hB00, 5'd1, 1, 0, 0, 1); step();
        instr(32'h8000_0000, 32'h8000_0000, 32'hC00, 5'd1, 1, 0, 0, 1); exc_ack = 1; step();
        chk("ackx_pend", 32'(exc_pending), 32'd1);
        chk("ackx_epc", epc, 32'hC00);
        chk("ackx_xflush", 32'(exc_flush), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, s;
            int unsigned kind;
            idle();
            a = $urandom;
            b = $urandom;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin a = 32'h7FFF_FFFF - $urandom_range(0, 3); b = $urandom_range(0, 8); end
            if (kind == 1) b = -a;
            ex_mem_read  = ($urandom_range(0, 3) == 0);
            ex_mem_write = !ex_mem_read && ($urandom_range(0, 3) == 0);
            s = a + b;
            if ((ex_mem_read || ex_mem_write) && $urandom_range(0, 3) != 0) b = b - (s & 32'd3);
            ex_sum        = a + b;
            ex_cout       = ripple_cout(a, b);
            ex_valid      = ($urandom_range(0, 9) != 0);
            ex_ovf_trap   = $urandom_range(0, 1) != 0;
            ex_reg_write  = ex_mem_read || (!ex_mem_write && $urandom_range(0, 1) != 0);
            ex_rd         = 5'($urandom);
            ex_pc         = {$urandom, 2'b00} & 32'h00FF_FFFC;
            ex_store_data = $urandom;
            stall   = ($urandom_range(0, 6) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            exc_ack = ($urandom_range(0, 5) == 0);
            reset   = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
